// File: rtl/valid_ready_serializer_pkg.sv
// Shared types and sizing helpers for the valid/ready width-reducing serializer.
package valid_ready_serializer_pkg;

    typedef enum logic {
        EMPTY   = 1'b0,
        SENDING = 1'b1
    } state_e;

    // The beat index needs at least one bit, even for degenerate ratios.
    function automatic int index_width(input int ratio);
        return (ratio <= 2) ? 1 : $clog2(ratio);
    endfunction

    localparam int DEFAULT_RATIO = 4;
    localparam int INDEX_WIDTH   = index_width(DEFAULT_RATIO);

endpackage

// File: rtl/valid_ready_serializer.sv
// Wide-to-narrow valid/ready serializer: one WIDTH*RATIO word out as RATIO beats, LSB slice first.
// Optional read_last output is enabled by defining VALID_READY_SERIALIZER_LAST_EN.
module valid_ready_serializer
    import valid_ready_serializer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int RATIO = 4
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic [WIDTH*RATIO-1:0] write_data,
    input  logic                   write_valid,
    output logic                   write_ready,
    output logic [WIDTH-1:0]       read_data,
    output logic                   read_valid,
    input  logic                   read_ready,
`ifdef VALID_READY_SERIALIZER_LAST_EN
    output logic                   read_last,
`endif
    output logic                   idle
);

    localparam int                IDX_W    = index_width(RATIO);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(RATIO - 1);

    state_e                       state_q, state_d;
    logic [IDX_W-1:0]             index_q, index_d;
    logic [RATIO-1:0][WIDTH-1:0]  word_q, word_d;

    logic last_beat;
    logic write_fire;
    logic read_fire;

    assign last_beat   = (index_q == LAST_IDX);
    assign idle        = (state_q == EMPTY);
    assign read_valid  = (state_q == SENDING);
    // Accepting on the last-beat handshake keeps the output stream free of bubbles.
    assign write_ready = idle || (last_beat && read_ready);
    assign write_fire  = write_valid && write_ready;
    assign read_fire   = read_valid && read_ready;

    // The held word is shifted down each beat, so the current beat is always slice 0.
    assign read_data   = word_q[0];

`ifdef VALID_READY_SERIALIZER_LAST_EN
    assign read_last   = read_valid && last_beat;
`endif

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        word_d  = word_q;

        if (write_fire) begin
            word_d  = write_data;
            index_d = '0;
            state_d = SENDING;
        end else if (read_fire) begin
            if (last_beat) begin
                word_d  = '0;
                index_d = '0;
                state_d = EMPTY;
            end else begin
                word_d  = word_q >> WIDTH;
                index_d = index_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= EMPTY;
            index_q <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            word_q  <= word_d;
        end
    end

endmodule

// File: tb/tb_valid_ready_serializer.sv
// Scoreboard bench for valid_ready_serializer (WIDTH=8, RATIO=4), directed plus random traffic.
module tb_valid_ready_serializer;

    localparam int WIDTH = 8;
    localparam int RATIO = 4;

    logic                   clock = 1'b0;
    logic                   resetn = 1'b0;
    logic [WIDTH*RATIO-1:0] write_data = '0;
    logic                   write_valid = 1'b0;
    logic                   write_ready;
    logic [WIDTH-1:0]       read_data;
    logic                   read_valid;
    logic                   read_ready = 1'b0;
    logic                   idle;
`ifdef VALID_READY_SERIALIZER_LAST_EN
    logic                   read_last;
`endif

    valid_ready_serializer #(.WIDTH(WIDTH), .RATIO(RATIO)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .write_data  (write_data),
        .write_valid (write_valid),
        .write_ready (write_ready),
        .read_data   (read_data),
        .read_valid  (read_valid),
        .read_ready  (read_ready),
`ifdef VALID_READY_SERIALIZER_LAST_EN
        .read_last   (read_last),
`endif
        .idle        (idle)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Each entry: {last-of-word flag, beat byte}, in the order the beats must appear.
    logic [WIDTH:0] exp_q[$];
    logic           mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_word(input logic [WIDTH*RATIO-1:0] w);
        for (int i = 0; i < RATIO; i++)
            exp_q.push_back({(i == RATIO - 1), w[i*WIDTH +: WIDTH]});
    endtask

    task automatic half();
        @(negedge clock);
    endtask

    // Records an accepted word into the scoreboard, then advances to just after the next edge.
    task automatic tick();
        if (resetn && write_valid && write_ready)
            push_word(write_data);
        @(posedge clock);
        #1;
    endtask

    // Monitor: pops one expected beat per read handshake and checks hold-under-backpressure.
    logic           prev_ok = 1'b0;
    logic           prev_v  = 1'b0;
    logic           prev_r  = 1'b0;
    logic [WIDTH-1:0] prev_d = '0;

    always @(negedge clock) begin
        if (resetn && mon_en) begin
            if (prev_ok && prev_v && !prev_r) begin
                check("hold_valid", 32'(read_valid), 32'd1);
                check("hold_data", 32'(read_data), 32'(prev_d));
            end
            if (read_valid && read_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL beat_unexpected: got 0x%0h, expected no beat at %0t", read_data, $time);
                end else begin
                    check("beat_data", 32'(read_data), 32'(exp_q[0][WIDTH-1:0]));
`ifdef VALID_READY_SERIALIZER_LAST_EN
                    check("beat_last", 32'(read_last), 32'(exp_q[0][WIDTH]));
`endif
                    void'(exp_q.pop_front());
                end
            end
            prev_ok <= 1'b1;
            prev_v  <= read_valid;
            prev_r  <= read_ready;
            prev_d  <= read_data;
        end else begin
            prev_ok <= 1'b0;
        end
    end

    initial begin : stim
        logic [31:0] w0;
        logic        acc;
        int          n_acc;
        int          cyc;

        // Reset values while held in reset
        repeat (2) @(posedge clock);
        #1;
        check("rst_idle", 32'(idle), 32'd1);
        check("rst_write_ready", 32'(write_ready), 32'd1);
        check("rst_read_valid", 32'(read_valid), 32'd0);
        check("rst_read_data", 32'(read_data), 32'd0);
        resetn = 1'b1;
        mon_en = 1'b1;

        // Single word with continuous read_ready
        read_ready  = 1'b1;
        write_valid = 1'b1;
        write_data  = 32'hDDCCBBAA;
        half();
        check("single_accept_ready", 32'(write_ready), 32'd1);
        check("single_no_same_cycle_valid", 32'(read_valid), 32'd0);
        tick();
        write_valid = 1'b0;
        for (int k = 0; k < RATIO; k++) begin
            half();
            check("single_valid", 32'(read_valid), 32'd1);
            check("single_data", 32'(read_data), 32'(8'hAA + 8'(k * 8'h11)));
`ifdef VALID_READY_SERIALIZER_LAST_EN
            check("single_last", 32'(read_last), 32'(k == RATIO - 1));
`endif
            tick();
        end
        half();
        check("single_idle_after", 32'(idle), 32'd1);
        check("single_valid_after", 32'(read_valid), 32'd0);
        tick();

        // Back-to-back words, no bubble between them
        write_valid = 1'b1;
        write_data  = 32'h44332211;
        for (int k = 0; k <= 2 * RATIO; k++) begin
            half();
            if (k >= 1) begin
                check("b2b_valid", 32'(read_valid), 32'd1);
                check("b2b_data", 32'(read_data), 32'(8'(k * 8'h11)));
            end
            acc = write_valid && write_ready;
            if (acc && write_data == 32'h88776655)
                check("b2b_second_accept_beat", 32'(read_data), 32'h44);
            if (k == 1)
                check("b2b_busy_not_ready", 32'(write_ready), 32'd0);
            tick();
            if (acc) begin
                if (write_data == 32'h44332211) write_data = 32'h88776655;
                else write_valid = 1'b0;
            end
        end
        half();
        check("b2b_idle_after", 32'(idle), 32'd1);
        tick();

        // Backpressure on beat BB
        write_valid = 1'b1;
        write_data  = 32'hDDCCBBAA;
        half();
        tick();
        write_valid = 1'b0;
        half();
        check("bp_first_beat", 32'(read_data), 32'hAA);
        tick();
        read_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            half();
            check("bp_stall_data", 32'(read_data), 32'hBB);
            check("bp_stall_valid", 32'(read_valid), 32'd1);
            check("bp_stall_write_ready", 32'(write_ready), 32'd0);
            tick();
        end
        read_ready = 1'b1;
        half();
        check("bp_release_data", 32'(read_data), 32'hBB);
        tick();
        half();
        check("bp_next_data", 32'(read_data), 32'hCC);
        tick();
        half();
        tick();

        // Pending write with changing data while mid-word
        w0          = 32'h04030201;
        write_valid = 1'b1;
        write_data  = w0;
        half();
        tick();
        for (int k = 1; k <= RATIO; k++) begin
            write_data = $urandom;
            half();
            check("pend_data", 32'(read_data), 32'(w0[(k-1)*WIDTH +: WIDTH]));
            check("pend_write_ready", 32'(write_ready), 32'(k == RATIO));
            tick();
        end
        write_valid = 1'b0;
        for (int k = 0; k < RATIO + 1; k++) begin
            half();
            tick();
        end
        check("pend_drained", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset in the middle of a word
        write_valid = 1'b1;
        write_data  = 32'hCAFEF00D;
        half();
        tick();
        write_valid = 1'b0;
        half();
        tick();
        read_ready = 1'b0;
        half();
        #2;
        mon_en = 1'b0;
        resetn = 1'b0;
        #1;
        check("arst_idle", 32'(idle), 32'd1);
        check("arst_write_ready", 32'(write_ready), 32'd1);
        check("arst_read_valid", 32'(read_valid), 32'd0);
        check("arst_read_data", 32'(read_data), 32'd0);
`ifdef VALID_READY_SERIALIZER_LAST_EN
        check("arst_read_last", 32'(read_last), 32'd0);
`endif
        exp_q.delete();
        @(posedge clock);
        @(posedge clock);
        #1;
        resetn = 1'b1;
        mon_en = 1'b1;

        // Random traffic: 100 words, 50% valid and ready
        n_acc = 0;
        cyc   = 0;
        while (n_acc < 100 && cyc < 5000) begin
            if (!write_valid && ($urandom & 1) != 0) begin
                write_valid = 1'b1;
                write_data  = $urandom;
            end
            read_ready = 1'(($urandom & 1) != 0);
            half();
            acc = write_valid && write_ready;
            tick();
            if (acc) begin
                n_acc++;
                write_valid = 1'b0;
            end
            cyc++;
        end
        check("rand_words_accepted", 32'(n_acc), 32'd100);
        write_valid = 1'b0;
        read_ready  = 1'b1;
        for (int k = 0; k < 4 * RATIO && !(exp_q.size() == 0 && idle); k++) begin
            half();
            tick();
        end
        check("rand_drain_queue", 32'(exp_q.size()), 32'd0);
        check("rand_idle_end", 32'(idle), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
